// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared payload field widths and skid-stage state encoding
package pipe_stage_reg_pkg;

  localparam int RD_ADDR_W     = 5;
  localparam int RD_VAL_W      = 32;
  localparam int INS_TYPE_W    = 7;
  localparam int INS_DETAILS_W = 3;
  localparam int MEM_ADDR_W    = 32;
  localparam int MEM_VAL_W     = 32;
  localparam int FORWARD_W     = 1;

  localparam int PAYLOAD_W = RD_ADDR_W + RD_VAL_W + INS_TYPE_W + INS_DETAILS_W
                           + MEM_ADDR_W + MEM_VAL_W + FORWARD_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic logic [1:0] occ_of(state_t s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid buffer pipeline stage with freeze and flush
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W   = PAYLOAD_W,
  parameter logic [DATA_W-1:0]  NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept_w;
  logic              release_w;

  // Handshake outputs come only from registered state, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = occ_of(state_q);

  assign accept_w  = in_valid & in_ready & rdy_in & ~flush_in;
  assign release_w = out_valid & out_ready & rdy_in;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_in) begin
      state_d = ST_EMPTY;
      main_d  = NOP_WORD;
      skid_d  = NOP_WORD;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_w) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept_w && release_w) begin
            main_d = in_data;
          end else if (accept_w) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (release_w) begin
            state_d = ST_EMPTY;
            main_d  = NOP_WORD;
          end
        end
        ST_TWO: begin
          if (release_w) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_WORD;
          skid_d  = NOP_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_WORD;
      skid_q  <= NOP_WORD;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

  localparam int             W   = 112;
  localparam logic [W-1:0]   NOP = {28{4'hD}};

  logic         clk_in;
  logic         rst_n_in;
  logic         rdy_in;
  logic         flush_in;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int vectors;
  int miscompares;
  logic [W-1:0] mq[$];

  pipe_stage_reg #(.DATA_W(W), .NOP_WORD(NOP)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic expect_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // The stage is a FIFO of depth 2 whose head is shown; an empty stage shows the bubble word.
  task automatic check_model();
    expect_eq("out_valid", W'(out_valid), W'(mq.size() != 0));
    expect_eq("in_ready",  W'(in_ready),  W'(mq.size() < 2));
    expect_eq("occupancy", W'(occupancy), W'(mq.size()));
    expect_eq("out_data",  out_data, (mq.size() != 0) ? mq[0] : NOP);
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic rdy, input logic fl);
    bit acc, rel;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rdy_in    = rdy;
    flush_in  = fl;
    acc = v && (mq.size() < 2) && rdy && !fl;
    rel = (mq.size() != 0) && ordy && rdy;
    @(posedge clk_in);
    if (fl) begin
      mq.delete();
    end else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(d);
    end
    @(negedge clk_in);
    check_model();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n_in  = 1'b0;
    rdy_in    = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk_in);
    check_model();
    expect_eq("rst_out_data", out_data, NOP);
    rst_n_in = 1'b1;

    // streaming at full rate
    step(1'b1, W'(1), 1'b1, 1'b1, 1'b0);
    expect_eq("stream1", out_data, W'(1));
    step(1'b1, W'(2), 1'b1, 1'b1, 1'b0);
    expect_eq("stream2", out_data, W'(2));
    step(1'b1, W'(3), 1'b1, 1'b1, 1'b0);
    expect_eq("stream3", out_data, W'(3));
    expect_eq("stream_occ", W'(occupancy), W'(1));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // backpressure into the skid register
    step(1'b1, W'(32'hA), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(32'hB), 1'b0, 1'b1, 1'b0);
    expect_eq("bp_occ", W'(occupancy), W'(2));
    expect_eq("bp_in_ready", W'(in_ready), W'(0));
    expect_eq("bp_head", out_data, W'(32'hA));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    expect_eq("bp_second", out_data, W'(32'hB));
    expect_eq("bp_ready_back", W'(in_ready), W'(1));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // flush from TWO discards the same-cycle input
    step(1'b1, W'(32'h11), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(32'h12), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(32'hC), 1'b1, 1'b1, 1'b1);
    expect_eq("flush_occ", W'(occupancy), W'(0));
    expect_eq("flush_valid", W'(out_valid), W'(0));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    expect_eq("flush_no_c", W'(out_data == W'(32'hC)), W'(0));

    // flush wins even while frozen
    step(1'b1, W'(32'h21), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(32'h22), 1'b1, 1'b0, 1'b1);
    expect_eq("flush_frozen_occ", W'(occupancy), W'(0));

    // freeze holds ONE
    step(1'b1, W'(32'h5), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, W'(32'h9), 1'b1, 1'b0, 1'b0);
      expect_eq("freeze_occ", W'(occupancy), W'(1));
      expect_eq("freeze_data", out_data, W'(32'h5));
    end
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    expect_eq("freeze_release", W'(occupancy), W'(0));

    // drain ONE back to the bubble word
    step(1'b1, W'(32'h7), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    expect_eq("drain_data", out_data, NOP);

    // asynchronous reset mid-cycle while holding two entries
    step(1'b1, W'(32'h31), 1'b0, 1'b1, 1'b0);
    step(1'b1, W'(32'h32), 1'b0, 1'b1, 1'b0);
    #2 rst_n_in = 1'b0;
    #1;
    mq.delete();
    check_model();
    expect_eq("async_rst_data", out_data, NOP);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step(1'b1, W'(32'h41), 1'b0, 1'b1, 1'b0);
    expect_eq("post_rst_first", out_data, W'(32'h41));
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, 16'($urandom)},
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
